// File: rtl/rv_decode_stage.sv
// rv_decode_stage: RV32I/RV64I decode stage with registered output and one-entry skid buffer.
// Define RV_DECODE_ILLEGAL_EN to add the out_illegal flag port.
module rv_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_ir,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [XLEN-1:0]          out_imm,
    output logic [$clog2(XLEN)-1:0]  out_shamt,
    output logic [3:0]               out_funct,
    output logic [2:0]               out_op2_sel,
    output logic [1:0]               out_target,
`ifdef RV_DECODE_ILLEGAL_EN
    output logic                     out_illegal,
`endif
    output logic                     out_we
);
    localparam int SW = $clog2(XLEN);
    localparam logic [3:0] F_ADD = 4'b0000, F_SLT = 4'b0010, F_SLTU = 4'b0011, F_SUB = 4'b1000;
    localparam logic [2:0] O_RS2 = 3'd0, O_I = 3'd1, O_S = 3'd2, O_B = 3'd3, O_U = 3'd4, O_J = 3'd5;
    localparam logic [1:0] T_JALR = 2'd0, T_JAL_BXX = 2'd1, T_PC4 = 2'd2;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [SW-1:0]   shamt;
        logic [3:0]      funct;
        logic [2:0]      op2_sel;
        logic [1:0]      target;
        logic            we;
`ifdef RV_DECODE_ILLEGAL_EN
        logic            illegal;
`endif
    } bundle_t;

    function automatic bundle_t nop_bundle();
        bundle_t b;
        b = '0;
        b.op2_sel = O_I;
        b.target = T_PC4;
        return b;
    endfunction

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic [3:0]  funct;
    logic [2:0]  op2;
    logic [1:0]  tgt;
    logic        wr, bad, sh_bad, accept;
    bundle_t     dec, out_q, skid_q;
    logic        skid_valid;

    assign opc = in_ir[6:0];
    assign f3 = in_ir[14:12];
    assign f7 = in_ir[31:25];
    assign imm_i = {{20{in_ir[31]}}, in_ir[31:20]};
    assign imm_s = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
    assign imm_b = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
    assign imm_u = {in_ir[31:12], 12'b0};
    assign imm_j = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
    // Shift-immediate upper bits: only ir[30] is allowed, and only for SRAI; ir[25] is shamt[5] on RV64
    assign sh_bad = in_ir[31] | (|in_ir[29:26]) | (f3 == 3'b001 && in_ir[30]) | (XLEN == 32 && in_ir[25]);

    always_comb begin
        op2 = O_I;
        funct = F_ADD;
        tgt = T_PC4;
        wr = 1'b1;
        bad = 1'b0;
        case (opc)
            7'b0110011: begin
                op2 = O_RS2;
                funct = {in_ir[30], f3};
                bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            7'b0010011: begin
                funct = {f3 == 3'b101 && in_ir[30], f3};
                bad = f3[1:0] == 2'b01 && sh_bad;
            end
            7'b0000011: ;
            7'b0100011: begin
                op2 = O_S;
                wr = 1'b0;
            end
            7'b1100011: begin
                op2 = O_B;
                wr = 1'b0;
                funct = f3[2:1] == 2'b00 ? F_SUB : f3[1] ? F_SLTU : F_SLT;
            end
            7'b0110111, 7'b0010111: op2 = O_U;
            7'b1101111: begin
                op2 = O_J;
                tgt = T_JAL_BXX;
            end
            7'b1100111: tgt = T_JALR;
            default: bad = 1'b1;
        endcase
        imm32 = op2 == O_S ? imm_s : op2 == O_B ? imm_b : op2 == O_U ? imm_u :
                op2 == O_J ? imm_j : op2 == O_RS2 ? 32'd0 : imm_i;
        dec = nop_bundle();
        if (!bad) begin
            dec.pc = in_pc;
            dec.rd = in_ir[11:7];
            dec.rs1 = in_ir[19:15];
            dec.rs2 = in_ir[24:20];
            dec.imm = XLEN'($signed(imm32));
            dec.shamt = in_ir[20 +: SW];
            dec.funct = funct;
            dec.op2_sel = op2;
            dec.target = tgt;
            dec.we = wr && in_ir[11:7] != 5'd0;
        end
`ifdef RV_DECODE_ILLEGAL_EN
        dec.illegal = bad;
`endif
    end

    assign in_ready = !skid_valid;
    assign accept = in_valid && in_ready;

    // Skid drains before any new input can reach the output, keeping order
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            skid_valid <= 1'b0;
            out_q <= nop_bundle();
            skid_q <= nop_bundle();
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            out_q <= skid_valid ? skid_q : dec;
            out_valid <= skid_valid || accept;
            skid_valid <= 1'b0;
        end else if (accept) begin
            skid_q <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_pc = out_q.pc;
    assign out_rd = out_q.rd;
    assign out_rs1 = out_q.rs1;
    assign out_rs2 = out_q.rs2;
    assign out_imm = out_q.imm;
    assign out_shamt = out_q.shamt;
    assign out_funct = out_q.funct;
    assign out_op2_sel = out_q.op2_sel;
    assign out_target = out_q.target;
    assign out_we = out_q.we;
`ifdef RV_DECODE_ILLEGAL_EN
    assign out_illegal = out_q.illegal;
`endif
endmodule
